// File: rtl/min_max_tracker.sv
// Frame-based running min/max tracker: accepts FRAME unsigned samples after a
// start, reporting the extreme values and the frame index where each first occurred.
module min_max_tracker #(
    parameter int N     = 8,
    parameter int FRAME = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] min_out,
    output logic [N-1:0] max_out,
    output logic [7:0]   min_idx,
    output logic [7:0]   max_idx,
    output logic [7:0]   count
);

    typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(FRAME - 1);

    state_t state, state_nxt;
    logic   accept;
    logic   min_lt, max_lt;

    assign accept = in_valid && in_ready;
    // Strict less-than only: equal samples never displace the earlier index.
    assign min_lt = in_data < min_out;
    assign max_lt = max_out < in_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = FIRST;
            FIRST: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && count == LAST_CNT) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results persist across DONE/IDLE/FIRST and are only replaced on the first accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_out <= '0;
            max_out <= '0;
            min_idx <= '0;
            max_idx <= '0;
            count   <= '0;
        end else if (accept) begin
            if (state == FIRST) begin
                min_out <= in_data;
                max_out <= in_data;
                min_idx <= '0;
                max_idx <= '0;
                count   <= 8'd1;
            end else begin
                if (min_lt) begin
                    min_out <= in_data;
                    min_idx <= count;
                end
                if (max_lt) begin
                    max_out <= in_data;
                    max_idx <= count;
                end
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_min_max_tracker.sv
// Directed bench for min_max_tracker (N=8, FRAME=4): queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_min_max_tracker;

    localparam int N     = 8;
    localparam int FRAME = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         in_ready, busy, done;
    logic [N-1:0] min_out, max_out;
    logic [7:0]   min_idx, max_idx, count;

    min_max_tracker #(.N(N), .FRAME(FRAME)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done),
        .min_out(min_out), .max_out(max_out),
        .min_idx(min_idx), .max_idx(max_idx), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the current frame's accepted samples live in a queue;
    // outputs are derived by scanning it.
    logic [N-1:0] q[$];
    bit m_busy = 0, m_done = 0, m_fresh = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 0; m_done = 0; m_fresh = 0;
                q.delete();
            end else if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (in_valid) begin
                    if (m_fresh) begin q.delete(); m_fresh = 0; end
                    q.push_back(in_data);
                    if (q.size() == FRAME) begin m_busy = 0; m_done = 1; end
                end
            end else if (start) begin
                m_busy = 1; m_fresh = 1;
            end
        end
    end

    initial begin
        logic [N-1:0] emin, emax;
        int imin, imax;
        forever begin
            @(negedge clk);
            if (done) done_seen++;
            if (mon_en) begin
                emin = '0; emax = '0; imin = 0; imax = 0;
                for (int i = 0; i < q.size(); i++) begin
                    if (i == 0 || q[i] < emin) begin emin = q[i]; imin = i; end
                    if (i == 0 || q[i] > emax) begin emax = q[i]; imax = i; end
                end
                check("mdl_in_ready", 32'(in_ready), 32'(m_busy));
                check("mdl_busy",     32'(busy),     32'(m_busy));
                check("mdl_done",     32'(done),     32'(m_done));
                check("mdl_count",    32'(count),    32'(q.size()));
                check("mdl_min_out",  32'(min_out),  32'(emin));
                check("mdl_max_out",  32'(max_out),  32'(emax));
                check("mdl_min_idx",  32'(min_idx),  32'(imin));
                check("mdl_max_idx",  32'(max_idx),  32'(imax));
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one sample and returns just after the edge that accepted it,
    // leaving in_valid high so consecutive calls are back-to-back.
    task automatic send(input logic [N-1:0] d);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: sample %0h not accepted within 20 cycles", d);
        end
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        tick(n);
    endtask

    task automatic check_res(input string s, input logic [7:0] mn, input logic [7:0] mi,
                             input logic [7:0] mx, input logic [7:0] xi, input logic [7:0] c);
        check({s, "_min_out"}, 32'(min_out), 32'(mn));
        check({s, "_min_idx"}, 32'(min_idx), 32'(mi));
        check({s, "_max_out"}, 32'(max_out), 32'(mx));
        check({s, "_max_idx"}, 32'(max_idx), 32'(xi));
        check({s, "_count"},   32'(count),   32'(c));
    endtask

    initial begin
        int d0;

        // Reset state
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check_res("rst", 8'h00, 0, 8'h00, 0, 0);

        // Frame 1: back-to-back, done one cycle after the 4th accept
        d0 = done_seen;
        do_start();
        check("s1_first_ready", 32'(in_ready), 1);
        send(8'h10); send(8'h05); send(8'hF0); send(8'h80);
        in_valid = 1'b0;
        check("s1_done_now", 32'(done), 1);
        check("s1_ready_in_done", 32'(in_ready), 0);
        check_res("s1", 8'h05, 1, 8'hF0, 2, 4);
        tick(2);
        check("s1_done_pulses", 32'(done_seen - d0), 1);

        // All-equal samples: ties keep index 0
        do_start();
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        gap(2);
        check_res("s2", 8'hFF, 0, 8'hFF, 0, 4);

        // Stalls between samples hold state
        do_start();
        send(8'h00); gap(3);
        check("s3_count_gap1", 32'(count), 1);
        send(8'hFF); gap(3);
        check("s3_count_gap2", 32'(count), 2);
        send(8'h00); gap(3);
        send(8'hFF); gap(2);
        check_res("s3", 8'h00, 0, 8'hFF, 1, 4);

        // Mid-frame reset, then valid without start must be ignored
        do_start();
        send(8'h40); send(8'h20);
        in_valid = 1'b0;
        check("s4_count_pre", 32'(count), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s4_in_ready", 32'(in_ready), 0);
        check("s4_busy", 32'(busy), 0);
        check_res("s4", 8'h00, 0, 8'h00, 0, 0);
        in_valid = 1'b1; in_data = 8'h55;
        tick(3);
        check("s4_no_accept", 32'(count), 0);
        check("s4_ready_idle", 32'(in_ready), 0);
        in_valid = 1'b0;

        // start held high throughout the frame
        d0 = done_seen;
        start = 1'b1;
        tick();
        send(8'h7F); send(8'h80); send(8'h01); send(8'hFE);
        in_valid = 1'b0;
        start = 1'b0;
        check("s5_done_now", 32'(done), 1);
        tick(2);
        check("s5_done_pulses", 32'(done_seen - d0), 1);
        check_res("s5", 8'h01, 2, 8'hFE, 3, 4);

        // Consecutive frame: results held through IDLE/FIRST, replaced at first accept
        do_start();
        check("s6_busy_first", 32'(busy), 1);
        check_res("s6_held", 8'h01, 2, 8'hFE, 3, 4);
        send(8'h33);
        check_res("s6_first", 8'h33, 0, 8'h33, 0, 1);
        send(8'h22); send(8'h44); send(8'h11);
        gap(2);
        check_res("s6", 8'h11, 3, 8'h44, 2, 4);

        tick(2);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/min_max_tracker.md
MIN_MAX_TRACKER -- requirements
Module: min_max_tracker

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning sample width in bits.
REQ-002 The block SHALL have parameter FRAME, default 16, meaning samples per frame, legal range 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: begins a frame; sampled only in IDLE.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data holds a sample.
REQ-007 The block SHALL have port in_data, input, N bits: unsigned sample.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-009 The block SHALL have port busy, output, 1 bit: high in FIRST and RUN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle frame-complete pulse.
REQ-011 The block SHALL have ports min_out and max_out, output, N bits each: running minimum and maximum.
REQ-012 The block SHALL have ports min_idx and max_idx, output, 8 bits each: frame index (0-based) of the current min and max.
REQ-013 The block SHALL have port count, output, 8 bits: samples accepted in the current frame.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, FIRST, RUN and DONE.
REQ-015 A sample SHALL be accepted on a cycle with in_valid=1 and in_ready=1; no other cycle changes count, min or max.
REQ-016 in_ready SHALL be 1 in FIRST and RUN and 0 in IDLE and DONE; in_ready SHALL NOT depend combinationally on in_valid.
REQ-017 IDLE with start=1 SHALL go to FIRST next cycle; start SHALL be ignored in every other state.
REQ-018 An accept in FIRST SHALL load min_out=max_out=in_data, min_idx=max_idx=0 and count=1, then go to RUN.
REQ-019 An accept in RUN SHALL compare in_data to the stored min and max as unsigned N-bit values, using the comparator's EQ/LT semantics.
REQ-020 If in_data is less than min_out, the accept SHALL load min_out=in_data and min_idx=count.
REQ-021 If max_out is less than in_data, the accept SHALL load max_out=in_data and max_idx=count.
REQ-022 On equality, min and max SHALL NOT update, so ties keep the earliest index.
REQ-023 Each accept in RUN SHALL increment count by 1.
REQ-024 The accept that brings count to FRAME SHALL move the FSM to DONE on the same clock edge.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL go to IDLE on the next cycle.
REQ-026 min_out, max_out, min_idx, max_idx and count SHALL hold their final values through DONE and IDLE until the first accept of the next frame.
REQ-027 Entering FIRST SHALL NOT clear the results; they change only at the first accept.
REQ-028 A stall (in_valid=0) in FIRST or RUN SHALL hold all state; there SHALL be no timeout.
REQ-029 Latency SHALL be: last accept at edge k gives done=1 in the cycle after edge k.
REQ-030 The minimum frame time SHALL be 1 (start) + FRAME + 1 (DONE) cycles.

Reset
REQ-031 When rst=1 at a rising clk edge, the block SHALL enter IDLE regardless of state, including mid-frame.
REQ-032 Reset SHALL clear min_out, max_out, min_idx, max_idx and count to 0.
REQ-033 The cycle after reset SHALL have in_ready=0, busy=0 and done=0.
REQ-034 rst SHALL take priority over start and over an in-flight accept on the same edge.
REQ-035 After reset, a new start SHALL be required before any sample is accepted.

Verification (N=8, FRAME=4)
REQ-036 The bench SHALL cover: start, then back-to-back 10,05,F0,80 (hex) -> min_out=05, min_idx=1, max_out=F0, max_idx=2, count=4; done high exactly once, one cycle after the 4th accept.
REQ-037 The bench SHALL cover: samples FF,FF,FF,FF -> min_out=max_out=FF, min_idx=max_idx=0.
REQ-038 The bench SHALL cover: samples 00,FF,00,FF with in_valid low for 3 cycles between each -> count holds during gaps; min_out=00, min_idx=0, max_out=FF, max_idx=1.
REQ-039 The bench SHALL cover: rst pulsed after the 2nd accept of 40,20 -> next cycle all outputs 0, in_ready=0; in_valid without start is not accepted.
REQ-040 The bench SHALL cover: start held high during RUN with samples 7F,80,01,FE -> no restart; min_out=01, min_idx=2, max_out=FE, max_idx=3; one done pulse.
REQ-041 The bench SHALL cover: two consecutive frames -> first-frame results held through IDLE and FIRST, replaced at the second frame's first accept.
